// File: rtl/mux_pkg.sv
// Shared constants for the 4-to-1 round-robin stream mux.
// Defaults for data/index widths, channel count and arbiter reset pointer.
package mux_pkg;

   localparam int WIDTH = 8;
   localparam int SNUM  = 2;
   localparam int NCH   = 4;

   // Pointer reset to 3 so channel 0 is first in line after reset.
   localparam logic [1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/mux_4to1_stream_rr_arb.sv
// Combinational 4-way round-robin arbiter, search starts at last+1.
// Ports: i_req, i_last in; o_gnt (one-hot), o_idx (encoded) out.
module rr_arbiter_4
   import mux_pkg::*;
(
   input  logic [NCH-1:0] i_req,
   input  logic [1:0]     i_last,
   output logic [NCH-1:0] o_gnt,
   output logic [1:0]     o_idx
);

   logic [1:0] w_cand;
   logic       w_hit;

   // Offsets 1..4 wrap mod 4; offset 4 revisits last itself.
   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      w_cand = '0;
      w_hit  = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
         w_cand = i_last + 2'(k);
         if (!w_hit && i_req[w_cand]) begin
            o_gnt[w_cand] = 1'b1;
            o_idx         = w_cand;
            w_hit         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_4to1_stream_rr.sv
// Registered 4-to-1 valid/ready stream mux, round-robin, source-tagged.
// Ports: clk, rst_n, i0..i3, i_valid, i_ready, o, o_sel, o_valid, o_ready.
module mux_4to1_stream_rr
   import mux_pkg::*;
#(
   parameter int width = WIDTH,
   parameter int snum  = SNUM
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] i0,
   input  logic [width-1:0] i1,
   input  logic [width-1:0] i2,
   input  logic [width-1:0] i3,
   input  logic [3:0]       i_valid,
   output logic [3:0]       i_ready,
   output logic [width-1:0] o,
   output logic [snum-1:0]  o_sel,
   output logic             o_valid,
   input  logic             o_ready
);

   logic [width-1:0] r_o;
   logic [snum-1:0]  r_sel;
   logic             r_valid;
   logic [1:0]       r_last;

   logic [3:0]       w_gnt;
   logic [1:0]       w_idx;
   logic             w_load;
   logic [width-1:0] w_data;

   rr_arbiter_4 u_arb (
      .i_req  (i_valid),
      .i_last (r_last),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx)
   );

   assign w_load = !r_valid | o_ready;

   // Gated by rst_n so nothing is accepted while reset is held.
   assign i_ready = w_gnt & {4{w_load & rst_n}};

   always_comb begin
      w_data = i0;
      case (w_idx)
         2'd0:    w_data = i0;
         2'd1:    w_data = i1;
         2'd2:    w_data = i2;
         default: w_data = i3;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_o     <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
         r_last  <= LAST_RST;
      end else if (w_load) begin
         if (|w_gnt) begin
            r_o     <= w_data;
            r_sel   <= snum'(w_idx);
            r_valid <= 1'b1;
            r_last  <= w_idx;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o       = r_o;
   assign o_sel   = r_sel;
   assign o_valid = r_valid;

endmodule

// File: tb/tb_mux_4to1_stream_rr.sv
// Directed bench for mux_4to1_stream_rr.
// Drives at posedge+1, checks registered outputs after each edge.
module tb_mux_4to1_stream_rr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] i0, i1, i2, i3;
   logic [3:0] i_valid;
   logic [3:0] i_ready;
   logic [7:0] o;
   logic [1:0] o_sel;
   logic       o_valid;
   logic       o_ready;

   int checks = 0;
   int errors = 0;

   mux_4to1_stream_rr #(.width(8), .snum(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i0      (i0),
      .i1      (i1),
      .i2      (i2),
      .i3      (i3),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .o       (o),
      .o_sel   (o_sel),
      .o_valid (o_valid),
      .o_ready (o_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      i0      = 8'h10;
      i1      = 8'h11;
      i2      = 8'h12;
      i3      = 8'h13;
      i_valid = 4'hF;
      o_ready = 1'b0;
      #3;
      chk("rst_ovalid", 32'(o_valid), 32'd0);
      chk("rst_o", 32'(o), 32'd0);
      chk("rst_sel", 32'(o_sel), 32'd0);
      chk("rst_iready", 32'(i_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      o_ready = 1'b1;
      #1;

      // Fairness: all valid, full rate, order 0,1,2,3,0,...
      for (int n = 0; n < 8; n++) begin
         chk("fair_iready", 32'(i_ready), 32'(4'b0001 << (n % 4)));
         tick();
         chk("fair_sel", 32'(o_sel), 32'(n % 4));
         chk("fair_o", 32'(o), 32'(8'h10 + (n % 4)));
         chk("fair_ovalid", 32'(o_valid), 32'd1);
      end

      // Park 8'h11 in the output (last=3 -> ch1 only valid).
      i_valid = 4'b0010;
      tick();
      chk("bp_setup_o", 32'(o), 32'h11);
      chk("bp_setup_sel", 32'(o_sel), 32'd1);

      // Backpressure three cycles with everyone valid.
      o_ready = 1'b0;
      i_valid = 4'hF;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk("bp_iready", 32'(i_ready), 32'd0);
         tick();
         chk("bp_o", 32'(o), 32'h11);
         chk("bp_valid", 32'(o_valid), 32'd1);
      end

      // Release: last still 1, so ch2 loads on this same edge.
      o_ready = 1'b1;
      #1;
      chk("bp_rel_iready", 32'(i_ready), 32'b0100);
      tick();
      chk("bp_rel_o", 32'(o), 32'h12);
      chk("bp_rel_sel", 32'(o_sel), 32'd2);

      // Single source.
      i_valid = 4'b0100;
      i2 = 8'hA5;
      #1;
      chk("single_iready", 32'(i_ready), 32'b0100);
      tick();
      i_valid = 4'b0000;
      chk("single_o", 32'(o), 32'hA5);
      chk("single_sel", 32'(o_sel), 32'd2);
      chk("single_valid", 32'(o_valid), 32'd1);

      // Drain.
      tick();
      chk("drain_valid", 32'(o_valid), 32'd0);
      chk("drain_o", 32'(o), 32'hA5);
      chk("drain_sel", 32'(o_sel), 32'd2);

      // No idle rotation: grant 3, idle 5, then 1001 -> ch0.
      i_valid = 4'b1000;
      i3 = 8'h33;
      tick();
      chk("rot_sel3", 32'(o_sel), 32'd3);
      chk("rot_o3", 32'(o), 32'h33);
      i_valid = 4'b0000;
      for (int n = 0; n < 5; n++) tick();
      chk("rot_idle_valid", 32'(o_valid), 32'd0);
      i_valid = 4'b1001;
      #1;
      chk("rot_iready", 32'(i_ready), 32'b0001);
      tick();
      chk("rot_sel0", 32'(o_sel), 32'd0);
      chk("rot_o0", 32'(o), 32'h10);
      #1;
      chk("rot_next_iready", 32'(i_ready), 32'b1000);
      tick();
      chk("rot_next_sel", 32'(o_sel), 32'd3);

      // Asynchronous reset mid-stream.
      chk("pre_rst_valid", 32'(o_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(o_valid), 32'd0);
      chk("arst_o", 32'(o), 32'd0);
      chk("arst_sel", 32'(o_sel), 32'd0);
      i_valid = 4'b1010;
      #1;
      chk("arst_iready", 32'(i_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_iready", 32'(i_ready), 32'b0010);
      tick();
      chk("post_rst_sel", 32'(o_sel), 32'd1);
      chk("post_rst_o", 32'(o), 32'h11);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
